// File: rtl/connect4_pkg.sv
// connect4_pkg: shared constants, state encoding and cell-address helper for
// the Connect Four turn sequencer.
// Board cell (r, c), r=0 bottom: A bit = 14r+2c+1, B bit = 14r+2c.
package connect4_pkg;

  localparam int ROWS       = 6;
  localparam int COLS       = 7;
  localparam int ROW_STRIDE = 14;
  localparam int GRID_W     = 98;
  localparam int MAX_MOVES  = 42;

  // Two locations that, written back to back, touch every win-detector
  // partial register that ordinary locations can leave stale.
  localparam logic [6:0] FLUSH_LOC_A = 7'd49;
  localparam logic [6:0] FLUSH_LOC_B = 7'd51;

  typedef enum logic [2:0] {
    FLUSH0,
    FLUSH1,
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic       PLAYER_A = 1'b0;
  localparam logic       PLAYER_B = 1'b1;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  // A-bit address of cell (r, c); 14r built from shifts, max 83 fits 7 bits.
  function automatic logic [6:0] cell_loc(input logic [2:0] r, input logic [2:0] c);
    logic [6:0] r7;
    logic [6:0] c7;
    r7 = {4'b0000, r};
    c7 = {4'b0000, c};
    return (r7 << 3) + (r7 << 2) + (r7 << 1) + (c7 << 1) + 7'd1;
  endfunction

endpackage

// File: rtl/drop_ctrl.sv
// drop_ctrl: Connect Four turn sequencer. Accepts column drops, places the
// current player's piece, owns grid/location for the win detector and
// decides win / draw / next turn two edges after each accepted drop.
// Ports: clk, rst (sync, active-high), new_game, drop, col_sel[2:0],
//        winner_in -> grid[97:0], location[6:0], ready, turn, illegal,
//        game_over, win_player[1:0], draw, move_count[5:0].
module drop_ctrl
  import connect4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              new_game,
  input  logic              drop,
  input  logic [2:0]        col_sel,
  input  logic              winner_in,
  output logic [GRID_W-1:0] grid,
  output logic [6:0]        location,
  output logic              ready,
  output logic              turn,
  output logic              illegal,
  output logic              game_over,
  output logic [1:0]        win_player,
  output logic              draw,
  output logic [5:0]        move_count
);

  // Only the 84 playable cell bits may ever be set.
  localparam logic [GRID_W-1:0] CELL_MASK =
    {GRID_W{1'b1}} >> (GRID_W - ROW_STRIDE * ROWS);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] height [COLS];

  logic       col_ok;
  logic [2:0] land_row;
  logic       legal;
  logic       accept;
  logic       reject;
  logic [6:0] land_loc;
  logic [6:0] land_bit;

  // Height is read only for a valid column, so col_sel=7 never indexes out.
  assign col_ok   = (col_sel < 3'(COLS));
  assign land_row = col_ok ? height[col_sel] : 3'd0;
  assign legal    = col_ok && (land_row != 3'(ROWS));
  assign accept   = (state == IDLE) && drop && legal;
  assign reject   = (state == IDLE) && drop && !legal;
  assign land_loc = cell_loc(land_row, col_sel);
  // B's bit sits one below A's bit in the same cell.
  assign land_bit = land_loc - {6'b000000, turn};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    game_over = 1'b0;
    case (state)
      FLUSH0: state_nxt = FLUSH1;
      FLUSH1: state_nxt = IDLE;
      IDLE: begin
        ready = 1'b1;
        if (accept) state_nxt = WAIT;
      end
      WAIT:  state_nxt = CHECK;
      CHECK: begin
        if (winner_in || (move_count == 6'(MAX_MOVES))) state_nxt = DONE;
        else                                             state_nxt = IDLE;
      end
      DONE: game_over = 1'b1;
      default: state_nxt = FLUSH0;
    endcase
    if (new_game) state_nxt = FLUSH0;
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      grid       <= '0;
      location   <= FLUSH_LOC_A;
      turn       <= PLAYER_A;
      illegal    <= 1'b0;
      win_player <= WIN_NONE;
      draw       <= 1'b0;
      move_count <= '0;
      for (int i = 0; i < COLS; i++) height[i] <= '0;
    end else begin
      illegal <= reject;
      case (state)
        FLUSH0: begin
          grid     <= '0;
          location <= FLUSH_LOC_B;
        end
        IDLE: begin
          if (accept) begin
            grid            <= (grid | (GRID_W'(1) << land_bit)) & CELL_MASK;
            location        <= land_loc;
            height[col_sel] <= land_row + 3'd1;
            move_count      <= move_count + 6'd1;
          end
        end
        CHECK: begin
          // winner_in is meaningful only here; a win on move 42 beats draw.
          if (winner_in) begin
            win_player <= (turn == PLAYER_B) ? WIN_B : WIN_A;
          end else if (move_count == 6'(MAX_MOVES)) begin
            draw <= 1'b1;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_ctrl.sv
module tb_drop_ctrl;

  logic        clk = 1'b0;
  logic        rst, new_game, drop, winner_in;
  logic [2:0]  col_sel;
  logic [97:0] grid;
  logic [6:0]  location;
  logic        ready, turn, illegal, game_over, draw;
  logic [1:0]  win_player;
  logic [5:0]  move_count;

  logic win_reg;
  logic glitch;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  drop_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game), .drop(drop),
    .col_sel(col_sel), .winner_in(winner_in), .grid(grid),
    .location(location), .ready(ready), .turn(turn), .illegal(illegal),
    .game_over(game_over), .win_player(win_player), .draw(draw),
    .move_count(move_count)
  );

  // Four-in-a-row check on a board image, used both by the stand-in win
  // detector and by the reference model.
  function automatic logic has_four(input logic [97:0] g);
    int  dr, dc, rr, cc;
    logic ok;
    has_four = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          for (int d = 0; d < 4; d++) begin
            case (d)
              0: begin dr = 0; dc = 1;  end
              1: begin dr = 1; dc = 0;  end
              2: begin dr = 1; dc = 1;  end
              default: begin dr = 1; dc = -1; end
            endcase
            ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
              rr = r + k * dr;
              cc = c + k * dc;
              if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
              else if (!g[14 * rr + 2 * cc + (p == 0 ? 1 : 0)]) ok = 1'b0;
            end
            if (ok) has_four = 1'b1;
          end
  endfunction

  // Stand-in for the registered win detector.
  always @(posedge clk) win_reg <= has_four(grid);
  assign winner_in = win_reg | glitch;

  // Reference model: board contents, move timing as cycle counts.
  logic [97:0] m_grid;
  int m_hgt [8];
  int m_mv, m_loc, m_win, m_flush, m_pend;
  bit m_turn, m_draw, m_over, m_ill;

  task automatic m_edge(input bit r, input bit ng, input bit d, input int c);
    int row;
    if (r || ng) begin
      m_grid = '0;
      for (int i = 0; i < 8; i++) m_hgt[i] = 0;
      m_mv = 0; m_turn = 0; m_win = 0; m_draw = 0; m_over = 0; m_ill = 0;
      m_flush = 2; m_pend = 0; m_loc = 49;
    end else begin
      m_ill = 0;
      if (m_flush > 0) begin
        if (m_flush == 2) m_loc = 51;
        m_flush--;
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          if (has_four(m_grid)) begin m_win = m_turn ? 2 : 1; m_over = 1; end
          else if (m_mv == 42)  begin m_draw = 1; m_over = 1; end
          else m_turn = !m_turn;
        end
      end else if (!m_over && d) begin
        if (c > 6 || m_hgt[c] == 6) m_ill = 1;
        else begin
          row = m_hgt[c];
          m_grid[14 * row + 2 * c + (m_turn ? 0 : 1)] = 1'b1;
          m_loc = 14 * row + 2 * c + 1;
          m_hgt[c]++;
          m_mv++;
          m_pend = 2;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [97:0] act, input logic [97:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",      98'(ready),      98'(m_flush == 0 && m_pend == 0 && !m_over));
      chk("game_over",  98'(game_over),  98'(m_over));
      chk("turn",       98'(turn),       98'(m_turn));
      chk("illegal",    98'(illegal),    98'(m_ill));
      chk("win_player", 98'(win_player), 98'(m_win));
      chk("draw",       98'(draw),       98'(m_draw));
      chk("move_count", 98'(move_count), 98'(m_mv));
      chk("location",   98'(location),   98'(m_loc));
      chk("grid",       grid,            m_grid);
    end
  end

  task automatic cyc(input bit r, input bit ng, input bit d, input int c);
    rst = r; new_game = ng; drop = d; col_sel = 3'(c);
    @(posedge clk);
    #1;
    m_edge(r, ng, d, c);
    rst = 0; new_game = 0; drop = 0;
  endtask

  // One full move; hold keeps drop asserted while busy (must be ignored).
  task automatic move(input int c, input bit hold);
    cyc(0, 0, 1, c);
    cyc(0, 0, hold, c);
    cyc(0, 0, hold, c);
  endtask

  task automatic restart();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; new_game = 0; drop = 0; col_sel = 0; glitch = 0;
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0);
    chk("rst_location", 98'(location), 98'd49);
    chk("rst_ready",    98'(ready),    98'd0);
    cyc(0, 0, 0, 0);
    chk("flush_location", 98'(location), 98'd51);
    cyc(0, 0, 0, 0);
    chk("ready_up", 98'(ready), 98'd1);

    // First move: A into column 3.
    cyc(0, 0, 1, 3);
    chk("a_col3_bit7", 98'(grid[7]),   98'd1);
    chk("a_col3_loc",  98'(location),  98'd7);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 3);
    chk("a_col3_turn", 98'(turn),       98'd1);
    chk("a_col3_mc",   98'(move_count), 98'd1);

    // Vertical win for A in column 0.
    restart();
    for (int i = 0; i < 3; i++) begin
      move(0, 0);
      move(1, 1);
    end
    cyc(0, 0, 1, 0);
    chk("win_loc43",  98'(location),  98'd43);
    chk("win_early",  98'(game_over), 98'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("win_over",   98'(game_over),  98'd1);
    chk("win_player", 98'(win_player), 98'd1);
    cyc(0, 0, 1, 4);
    cyc(0, 0, 1, 4);
    chk("done_hold_mc", 98'(move_count), 98'd7);

    // Full column, then out-of-range column, with a stray winner_in in IDLE.
    restart();
    for (int i = 0; i < 6; i++) move(2, 1);
    glitch = 1;
    cyc(0, 0, 1, 2);
    chk("full_illegal", 98'(illegal),    98'd1);
    chk("full_mc",      98'(move_count), 98'd6);
    chk("full_turn",    98'(turn),       98'd0);
    cyc(0, 0, 0, 0);
    chk("illegal_1cyc", 98'(illegal), 98'd0);
    cyc(0, 0, 1, 7);
    chk("col7_illegal", 98'(illegal), 98'd1);
    cyc(0, 0, 0, 0);
    glitch = 0;
    chk("glitch_ignored", 98'(game_over), 98'd0);

    // 42-move draw: column colours alternate, column pairs staggered.
    restart();
    for (int p = 0; p < 3; p++) begin
      int x, y;
      x = (p == 0) ? 0 : (p == 1) ? 1 : 4;
      y = (p == 0) ? 2 : (p == 1) ? 3 : 6;
      for (int k = 0; k < 3; k++) begin
        move(x, 0); move(y, 0); move(y, 0); move(x, 0);
      end
    end
    for (int i = 0; i < 6; i++) move(5, 0);
    chk("draw_flag", 98'(draw),       98'd1);
    chk("draw_win",  98'(win_player), 98'd0);
    chk("draw_mc",   98'(move_count), 98'd42);
    chk("draw_over", 98'(game_over),  98'd1);

    // Abort a winning move with new_game while in CHECK.
    restart();
    for (int i = 0; i < 3; i++) begin
      move(0, 0);
      move(1, 0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("abort_win",  98'(win_player), 98'd0);
    chk("abort_over", 98'(game_over),  98'd0);
    chk("abort_grid", grid,            98'd0);
    chk("abort_loc",  98'(location),   98'd49);
    cyc(0, 0, 0, 0);
    chk("abort_loc51", 98'(location), 98'd51);
    cyc(0, 0, 0, 0);
    chk("abort_ready", 98'(ready), 98'd1);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
